// File: rtl/adbg_top_pkg.sv
// Shared constants and types for the N-module advanced debug top level.
package adbg_top_pkg;

    localparam int DBG_TOP_MODULE_DATA_LEN = 53;
    localparam int DBG_TOP_MODULE_ID_LEN   = 5;

    localparam int ADBG_MOD_AXI = 0;
    localparam int ADBG_MOD_CPU = 1;

    typedef enum logic [0:0] {
        PEND_IDLE = 1'b0,
        PEND_PEND = 1'b1
    } pend_state_e;

endpackage

// File: rtl/adbg_top_sel_ctrl.sv
// Module-select control: active module ID, sticky error/drop flags, optional pending select.
// Pending-select storage is built only when ADBG_TOP_SEL_PENDING_EN is defined.
module adbg_top_sel_ctrl
    import adbg_top_pkg::*;
#(
    parameter int NB_MODULES      = 4,
    parameter int MODULE_ID_WIDTH = DBG_TOP_MODULE_ID_LEN
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sel_evt_i,
    input  logic [MODULE_ID_WIDTH-1:0] id_in_i,
    input  logic                       inhibit_i,
    output logic [MODULE_ID_WIDTH-1:0] module_id_o,
    output logic                       sel_error_o,
    output logic                       sel_dropped_o
);

    // One extra bit so NB_MODULES == 2**MODULE_ID_WIDTH still compares correctly.
    localparam logic [MODULE_ID_WIDTH:0] NB_MODULES_W = (MODULE_ID_WIDTH+1)'(NB_MODULES);

    logic                       id_valid_s;
    logic [MODULE_ID_WIDTH-1:0] module_id_q, module_id_d;
    logic                       sel_error_q, sel_error_d;
    logic                       sel_dropped_q, sel_dropped_d;
`ifdef ADBG_TOP_SEL_PENDING_EN
    pend_state_e                pend_state_q, pend_state_d;
    logic [MODULE_ID_WIDTH-1:0] pend_id_q, pend_id_d;
`endif

    assign id_valid_s = ({1'b0, id_in_i} < NB_MODULES_W);

    // Next-state: invalid ID, direct select, inhibited select, then deferred apply.
    always_comb begin
        module_id_d   = module_id_q;
        sel_error_d   = sel_error_q;
        sel_dropped_d = sel_dropped_q;
`ifdef ADBG_TOP_SEL_PENDING_EN
        pend_state_d  = pend_state_q;
        pend_id_d     = pend_id_q;
`endif
        if (sel_evt_i) begin
            if (!id_valid_s) begin
                sel_error_d = 1'b1;
            end else if (!inhibit_i) begin
                module_id_d = id_in_i;
                sel_error_d = 1'b0;
`ifdef ADBG_TOP_SEL_PENDING_EN
                pend_state_d = PEND_IDLE;
`endif
            end else begin
`ifdef ADBG_TOP_SEL_PENDING_EN
                if (pend_state_q == PEND_PEND) begin
                    sel_dropped_d = 1'b1;
                end else begin
                    sel_dropped_d = sel_dropped_q;
                end
                pend_id_d    = id_in_i;
                pend_state_d = PEND_PEND;
`else
                sel_dropped_d = 1'b1;
`endif
            end
        end else begin
`ifdef ADBG_TOP_SEL_PENDING_EN
            if ((pend_state_q == PEND_PEND) && !inhibit_i) begin
                module_id_d  = pend_id_q;
                pend_state_d = PEND_IDLE;
            end else begin
                pend_state_d = pend_state_q;
            end
`else
            module_id_d = module_id_q;
`endif
        end
    end

    // Select state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            module_id_q   <= MODULE_ID_WIDTH'(ADBG_MOD_AXI);
            sel_error_q   <= 1'b0;
            sel_dropped_q <= 1'b0;
`ifdef ADBG_TOP_SEL_PENDING_EN
            pend_state_q  <= PEND_IDLE;
            pend_id_q     <= {MODULE_ID_WIDTH{1'b0}};
`endif
        end else begin
            module_id_q   <= module_id_d;
            sel_error_q   <= sel_error_d;
            sel_dropped_q <= sel_dropped_d;
`ifdef ADBG_TOP_SEL_PENDING_EN
            pend_state_q  <= pend_state_d;
            pend_id_q     <= pend_id_d;
`endif
        end
    end

    assign module_id_o   = module_id_q;
    assign sel_error_o   = sel_error_q;
    assign sel_dropped_o = sel_dropped_q;

endmodule

// File: rtl/adbg_top_mux_n.sv
// JTAG debug top for NB_MODULES sub-modules: DR shift register, select decode, TDO mux.
// Optional pending-select behaviour: define ADBG_TOP_SEL_PENDING_EN.
module adbg_top_mux_n
    import adbg_top_pkg::*;
#(
    parameter int NB_MODULES      = 4,
    parameter int MODULE_ID_WIDTH = DBG_TOP_MODULE_ID_LEN,
    parameter int DATA_LEN        = DBG_TOP_MODULE_DATA_LEN
) (
    input  logic                  tck_i,
    input  logic                  trstn_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic                  shift_dr_i,
    input  logic                  pause_dr_i,
    input  logic                  update_dr_i,
    input  logic                  capture_dr_i,
    input  logic                  debug_select_i,
    output logic [DATA_LEN-1:0]   data_register_o,
    output logic [NB_MODULES-1:0] module_select_o,
    input  logic [NB_MODULES-1:0] module_tdo_i,
    input  logic [NB_MODULES-1:0] module_inhibit_i,
    output logic                  sel_error_o,
    output logic                  sel_dropped_o
);

    logic [DATA_LEN-1:0]        sr_q, sr_d;
    logic                       select_cmd_s;
    logic [MODULE_ID_WIDTH-1:0] id_in_s;
    logic                       sel_evt_s;
    logic                       inhibit_s;
    logic [MODULE_ID_WIDTH-1:0] module_id_s;
    logic                       unused_capture_s;

    // Capture-DR leaves this block untouched; sub-modules load their own status.
    assign unused_capture_s = capture_dr_i;

    // Shift LSB-first toward bit 0; Pause-DR and every other state hold.
    always_comb begin
        if (debug_select_i && shift_dr_i && !pause_dr_i) begin
            sr_d = {tdi_i, sr_q[DATA_LEN-1:1]};
        end else begin
            sr_d = sr_q;
        end
    end

    // DR shift register.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            sr_q <= {DATA_LEN{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign data_register_o = sr_q;
    assign select_cmd_s    = sr_q[DATA_LEN-1];
    assign id_in_s         = sr_q[DATA_LEN-2 -: MODULE_ID_WIDTH];
    assign sel_evt_s       = debug_select_i && update_dr_i && select_cmd_s;
    assign inhibit_s       = |module_inhibit_i;

    adbg_top_sel_ctrl #(
        .NB_MODULES      (NB_MODULES),
        .MODULE_ID_WIDTH (MODULE_ID_WIDTH)
    ) u_sel_ctrl (
        .clk_i         (tck_i),
        .rst_ni        (trstn_i),
        .sel_evt_i     (sel_evt_s),
        .id_in_i       (id_in_s),
        .inhibit_i     (inhibit_s),
        .module_id_o   (module_id_s),
        .sel_error_o   (sel_error_o),
        .sel_dropped_o (sel_dropped_o)
    );

    // One-hot decode of the registered ID only, so select never glitches while shifting.
    always_comb begin
        module_select_o = {NB_MODULES{1'b0}};
        for (int i = 0; i < NB_MODULES; i++) begin
            module_select_o[i] = (module_id_s == MODULE_ID_WIDTH'(i));
        end
    end

    assign tdo_o = |(module_tdo_i & module_select_o);

endmodule

// File: tb/tb_adbg_top_mux_n.sv
// Self-checking bench for adbg_top_mux_n; expected select/flag states queued per command.
module tb_adbg_top_mux_n;

    localparam int NB  = 4;
    localparam int IDW = 5;
    localparam int DL  = 53;

    logic          tck_i = 1'b0;
    logic          trstn_i = 1'b1;
    logic          tdi_i = 1'b0;
    logic          shift_dr_i = 1'b0;
    logic          pause_dr_i = 1'b0;
    logic          update_dr_i = 1'b0;
    logic          capture_dr_i = 1'b0;
    logic          debug_select_i = 1'b0;
    logic [NB-1:0] module_tdo_i = 4'b0000;
    logic [NB-1:0] module_inhibit_i = 4'b0000;
    logic          tdo_o;
    logic [DL-1:0] data_register_o;
    logic [NB-1:0] module_select_o;
    logic          sel_error_o;
    logic          sel_dropped_o;

    typedef struct {
        string         name;
        logic [NB-1:0] sel;
        logic          err;
        logic          drop;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    adbg_top_mux_n dut (
        .tck_i            (tck_i),
        .trstn_i          (trstn_i),
        .tdi_i            (tdi_i),
        .tdo_o            (tdo_o),
        .shift_dr_i       (shift_dr_i),
        .pause_dr_i       (pause_dr_i),
        .update_dr_i      (update_dr_i),
        .capture_dr_i     (capture_dr_i),
        .debug_select_i   (debug_select_i),
        .data_register_o  (data_register_o),
        .module_select_o  (module_select_o),
        .module_tdo_i     (module_tdo_i),
        .module_inhibit_i (module_inhibit_i),
        .sel_error_o      (sel_error_o),
        .sel_dropped_o    (sel_dropped_o)
    );

    always #5 tck_i = ~tck_i;

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic shift_bits(input logic [DL-1:0] data, input int first, input int count);
        debug_select_i = 1'b1;
        shift_dr_i     = 1'b1;
        for (int i = first; i < first + count; i++) begin
            tdi_i = data[i];
            tick();
        end
        shift_dr_i = 1'b0;
    endtask

    function automatic logic [DL-1:0] sel_word(input logic [IDW-1:0] id);
        logic [DL-1:0] w;
        w = {DL{1'b0}};
        w[DL-1] = 1'b1;
        w[DL-2 -: IDW] = id;
        return w;
    endfunction

    task automatic push_exp(input string name, input logic [NB-1:0] sel, input logic err, input logic drop);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.err  = err;
        e.drop = drop;
        sb_q.push_back(e);
    endtask

    task automatic do_select(input string name, input logic [IDW-1:0] id,
                             input logic [NB-1:0] sel, input logic err, input logic drop);
        push_exp(name, sel, err, drop);
        shift_bits(sel_word(id), 0, DL);
        update_dr_i = 1'b1;
        tick();
        update_dr_i = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        #2 trstn_i = 1'b0;
        module_tdo_i = 4'b0001;
        push_exp("reset_state", 4'b0001, 1'b0, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
        checks++;
        if (data_register_o !== {DL{1'b0}}) begin
            errors++;
            $display("FAIL reset_sr got %h want 0", data_register_o);
        end
        checks++;
        if (tdo_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_tdo_hi got %b want 1", tdo_o);
        end
        module_tdo_i = 4'b1110;
        #1;
        checks++;
        if (tdo_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_tdo_lo got %b want 0", tdo_o);
        end
        tick();
        trstn_i = 1'b1;
        tick();
    endtask

    task automatic test_select_valid();
        exp_t          e;
        logic [DL-1:0] w;
        do_select("sel_id2", 5'd2, 4'b0100, 1'b0, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
        module_tdo_i = 4'b0100;
        #1;
        checks++;
        if (tdo_o !== 1'b1) begin
            errors++;
            $display("FAIL tdo_mod2_hi got %b want 1", tdo_o);
        end
        module_tdo_i = 4'b1011;
        #1;
        checks++;
        if (tdo_o !== 1'b0) begin
            errors++;
            $display("FAIL tdo_mod2_lo got %b want 0", tdo_o);
        end
        // Data command (MSB clear) with a plausible ID field must not reselect.
        w = {$urandom, $urandom};
        w[DL-1] = 1'b0;
        w[DL-2 -: IDW] = 5'd1;
        push_exp("data_update", 4'b0100, 1'b0, 1'b0);
        shift_bits(w, 0, DL);
        update_dr_i = 1'b1;
        tick();
        update_dr_i = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
        checks++;
        if (data_register_o !== w) begin
            errors++;
            $display("FAIL data_reg got %h want %h", data_register_o, w);
        end
    endtask

    task automatic test_invalid_id();
        exp_t e;
        do_select("bad_id7", 5'd7, 4'b0100, 1'b1, 1'b0);
        do_select("ok_id1",  5'd1, 4'b0010, 1'b0, 1'b0);
        do_select("bad_id4", 5'd4, 4'b0010, 1'b1, 1'b0);
        do_select("ok_id3",  5'd3, 4'b1000, 1'b0, 1'b0);
        do_select("ok_id0",  5'd0, 4'b0001, 1'b0, 1'b0);
        // All five commands were queued as issued; outputs now reflect only the last.
        while (sb_q.size() > 1) begin
            e = sb_q.pop_front();
        end
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
    endtask

    task automatic test_invalid_steps();
        exp_t e;
        logic [IDW-1:0] ids [4] = '{5'd7, 5'd1, 5'd4, 5'd3};
        logic [NB-1:0]  sels[4] = '{4'b0001, 4'b0010, 4'b0010, 4'b1000};
        logic           errs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            do_select($sformatf("step_id%0d", ids[k]), ids[k], sels[k], errs[k], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
                errors++;
                $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                         module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
            end
        end
        do_select("back_id0", 5'd0, 4'b0001, 1'b0, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
    endtask

    task automatic test_inhibit();
        exp_t e;
        module_inhibit_i = 4'b0001;
`ifdef ADBG_TOP_SEL_PENDING_EN
        do_select("inh_id3", 5'd3, 4'b0001, 1'b0, 1'b0);
        push_exp("inh_release", 4'b1000, 1'b0, 1'b0);
`else
        do_select("inh_id3", 5'd3, 4'b0001, 1'b0, 1'b1);
        push_exp("inh_release", 4'b0001, 1'b0, 1'b1);
`endif
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
        module_inhibit_i = 4'b0000;
        tick();
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
`ifdef ADBG_TOP_SEL_PENDING_EN
        module_inhibit_i = 4'b0010;
        do_select("pend_id1", 5'd1, 4'b1000, 1'b0, 1'b0);
        do_select("pend_id2", 5'd2, 4'b1000, 1'b0, 1'b1);
        push_exp("pend_release", 4'b0100, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            e = sb_q.pop_front();
        end
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
`else
        module_inhibit_i = 4'b0100;
        do_select("drop_id2", 5'd2, 4'b0001, 1'b0, 1'b1);
        push_exp("drop_release", 4'b0001, 1'b0, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
`endif
        module_inhibit_i = 4'b0000;
        tick();
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
    endtask

    task automatic test_pause();
        logic [DL-1:0] p;
        logic [DL-1:0] mid;
        trstn_i = 1'b0;
        tick();
        trstn_i = 1'b1;
        tick();
        p = {$urandom, $urandom};
        mid = {DL{1'b0}};
        mid[DL-1 -: 10] = p[9:0];
        shift_bits(p, 0, 10);
        checks++;
        if (data_register_o !== mid) begin
            errors++;
            $display("FAIL pause_pre got %h want %h", data_register_o, mid);
        end
        pause_dr_i = 1'b1;
        tdi_i = ~tdi_i;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        checks++;
        if (data_register_o !== mid) begin
            errors++;
            $display("FAIL pause_hold got %h want %h", data_register_o, mid);
        end
        pause_dr_i = 1'b0;
        shift_bits(p, 10, DL - 10);
        checks++;
        if (data_register_o !== p) begin
            errors++;
            $display("FAIL pause_full got %h want %h", data_register_o, p);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_select("rm_id2", 5'd2, 4'b0100, 1'b0, 1'b0);
        do_select("rm_bad", 5'd31, 4'b0100, 1'b1, 1'b0);
        module_inhibit_i = 4'b1000;
`ifdef ADBG_TOP_SEL_PENDING_EN
        do_select("rm_pend1", 5'd1, 4'b0100, 1'b1, 1'b0);
        do_select("rm_pend3", 5'd3, 4'b0100, 1'b1, 1'b1);
`else
        do_select("rm_drop1", 5'd1, 4'b0100, 1'b1, 1'b1);
`endif
        while (sb_q.size() > 1) begin
            e = sb_q.pop_front();
        end
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
        shift_bits({DL{1'b1}}, 0, 20);
        shift_dr_i = 1'b1;
        @(posedge tck_i);
        #2 trstn_i = 1'b0;
        push_exp("rm_async", 4'b0001, 1'b0, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
        checks++;
        if (data_register_o !== {DL{1'b0}}) begin
            errors++;
            $display("FAIL rm_sr got %h want 0", data_register_o);
        end
        shift_dr_i = 1'b0;
        tick();
        trstn_i = 1'b1;
        module_inhibit_i = 4'b0000;
        push_exp("rm_no_pending", 4'b0001, 1'b0, 1'b0);
        tick();
        tick();
        e = sb_q.pop_front();
        checks++;
        if ({module_select_o, sel_error_o, sel_dropped_o} !== {e.sel, e.err, e.drop}) begin
            errors++;
            $display("FAIL %s got sel=%b err=%b drop=%b want sel=%b err=%b drop=%b", e.name,
                     module_select_o, sel_error_o, sel_dropped_o, e.sel, e.err, e.drop);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_select_valid();
        test_invalid_id();
        test_invalid_steps();
        test_inhibit();
        test_pause();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
